// File: rtl/caxi4interconnect_write_data_pop_controller_if.sv
// Write-data pop controller bundle: AW grant push, master W handshake,
// slave W steering and the transaction-pop / WLAST-error indications.
interface caxi4interconnect_write_data_pop_controller_if #(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int LEN_WIDTH        = 8
);
  logic                        awPush;
  logic [MASTERID_WIDTH-1:0]   awPushID;
  logic [NUM_SLAVES_WIDTH-1:0] awPushSlaveID;
  logic [LEN_WIDTH-1:0]        awPushLen;
  logic                        awFull;
  logic                        mstWValid;
  logic                        mstWLast;
  logic                        mstWReady;
  logic [NUM_SLAVES-1:0]       slvWValid;
  logic [NUM_SLAVES-1:0]       slvWReady;
  logic                        slvWLast;
  logic [NUM_SLAVES_WIDTH-1:0] wSelSlaveID;
  logic [MASTERID_WIDTH-1:0]   currDataTransID;
  logic                        openTransDec;
  logic                        lastErrPulse;
  logic                        lastErrSticky;

  // The pop controller itself.
  modport slave (
    input  awPush, awPushID, awPushSlaveID, awPushLen,
    input  mstWValid, mstWLast, slvWReady,
    output awFull, mstWReady, slvWValid, slvWLast, wSelSlaveID,
    output currDataTransID, openTransDec, lastErrPulse, lastErrSticky
  );

  // Whatever drives grants and W traffic into the controller.
  modport master (
    output awPush, awPushID, awPushSlaveID, awPushLen,
    output mstWValid, mstWLast, slvWReady,
    input  awFull, mstWReady, slvWValid, slvWLast, wSelSlaveID,
    input  currDataTransID, openTransDec, lastErrPulse, lastErrSticky
  );
endinterface

// File: rtl/caxi4interconnect_write_data_pop_controller.sv
// Completion side of per-master open-transaction bookkeeping: queues granted
// write addresses in order, steers the master W channel to the granted
// slave, counts beats against AWLEN, pops the transaction on its last beat
// and flags master WLAST that disagrees with AWLEN.
module caxi4interconnect_write_data_pop_controller #(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int LEN_WIDTH        = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int FIFO_DEPTH_WIDTH = 2
) (
  input  logic sysClk,
  input  logic sysReset,
  caxi4interconnect_write_data_pop_controller_if.slave bus
);

  localparam int CNT_W = FIFO_DEPTH_WIDTH + 1;

  // Address queue storage and pointers.
  logic [MASTERID_WIDTH-1:0]   r_id_mem  [FIFO_DEPTH];
  logic [NUM_SLAVES_WIDTH-1:0] r_slv_mem [FIFO_DEPTH];
  logic [LEN_WIDTH-1:0]        r_len_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [FIFO_DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]            r_count;
  logic                        r_aw_full;

  // Burst progress and completion/error indications.
  logic [LEN_WIDTH-1:0]        r_beat_cnt;
  logic                        r_pop;
  logic [MASTERID_WIDTH-1:0]   r_curr_id;
  logic                        r_err_pulse;
  logic                        r_err_sticky;

  // Head-of-queue view and W handshake decode.
  logic                        w_head_valid;
  logic [MASTERID_WIDTH-1:0]   w_head_id;
  logic [NUM_SLAVES_WIDTH-1:0] w_head_slv;
  logic [LEN_WIDTH-1:0]        w_head_len;
  logic [NUM_SLAVES-1:0]       w_slv_wvalid;
  logic                        w_mst_wready;
  logic                        w_slv_wlast;
  logic                        w_beat;
  logic                        w_last_beat;
  logic                        w_push;
  logic [CNT_W-1:0]            w_count_nxt;

  // Head decode, W steering and beat qualification.
  always_comb begin
    // NOTE: every output of this block is given a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    w_head_valid = (r_count != '0);
    w_head_id    = '0;
    w_head_slv   = '0;
    w_head_len   = '0;
    if (w_head_valid) begin
      w_head_id  = r_id_mem[r_rd_ptr];
      w_head_slv = r_slv_mem[r_rd_ptr];
      w_head_len = r_len_mem[r_rd_ptr];
    end

    w_slv_wvalid = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      w_slv_wvalid[k] = w_head_valid & bus.mstWValid &
                        (w_head_slv == NUM_SLAVES_WIDTH'(k));
    end

    // W data arriving ahead of its AW entry stalls here.
    w_mst_wready = w_head_valid & bus.slvWReady[w_head_slv];
    // WLAST to the slave comes from AWLEN, never from the master.
    w_slv_wlast  = w_head_valid & (r_beat_cnt == w_head_len);
    w_beat       = bus.mstWValid & w_mst_wready;
    w_last_beat  = w_beat & w_slv_wlast;

    // A push while full is dropped even if a pop frees a slot this cycle.
    w_push       = bus.awPush & ~r_aw_full;
    w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_last_beat);
  end

  // Entry storage written on every accepted push.
  always_ff @(posedge sysClk) begin
    // NOTE: the storage array is deliberately not reset; entries are only
    // ever read while counted valid, so clearing them would add nothing.
    if (w_push) begin
      r_id_mem[r_wr_ptr]  <= bus.awPushID;
      r_slv_mem[r_wr_ptr] <= bus.awPushSlaveID;
      r_len_mem[r_wr_ptr] <= bus.awPushLen;
    end
  end

  // Queue pointers, occupancy and full flag.
  always_ff @(posedge sysClk) begin
    // NOTE: state registers use non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!sysReset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_aw_full <= 1'b0;
    end else begin
      if (w_push)      r_wr_ptr <= r_wr_ptr + FIFO_DEPTH_WIDTH'(1);
      if (w_last_beat) r_rd_ptr <= r_rd_ptr + FIFO_DEPTH_WIDTH'(1);
      r_count   <= w_count_nxt;
      r_aw_full <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  // Beat counter within the head burst; restarts on every last beat.
  always_ff @(posedge sysClk) begin
    if (!sysReset) begin
      r_beat_cnt <= '0;
    end else if (w_last_beat) begin
      r_beat_cnt <= '0;
    end else if (w_beat) begin
      r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
    end
  end

  // Pop pulse with the completed ID; the ID holds until the next pop.
  always_ff @(posedge sysClk) begin
    if (!sysReset) begin
      r_pop     <= 1'b0;
      r_curr_id <= '0;
    end else begin
      r_pop <= w_last_beat;
      if (w_last_beat) r_curr_id <= w_head_id;
    end
  end

  // WLAST mismatch detection: one-cycle pulse plus sticky flag.
  always_ff @(posedge sysClk) begin
    if (!sysReset) begin
      r_err_pulse  <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_pulse <= w_beat & (bus.mstWLast != w_slv_wlast);
      if (w_beat && (bus.mstWLast != w_slv_wlast)) r_err_sticky <= 1'b1;
    end
  end

  assign bus.awFull          = r_aw_full;
  assign bus.mstWReady       = w_mst_wready;
  assign bus.slvWValid       = w_slv_wvalid;
  assign bus.slvWLast        = w_slv_wlast;
  assign bus.wSelSlaveID     = w_head_slv;
  assign bus.currDataTransID = r_curr_id;
  assign bus.openTransDec    = r_pop;
  assign bus.lastErrPulse    = r_err_pulse;
  assign bus.lastErrSticky   = r_err_sticky;

endmodule

// File: tb/tb_caxi4interconnect_write_data_pop_controller.sv
// Self-checking bench for the write-data pop controller. Expected pop IDs
// are queued when an address push is driven and matched when the DUT pulses
// openTransDec; each scenario task also checks steering and flags inline.
module tb_caxi4interconnect_write_data_pop_controller;

  localparam int NS  = 4;
  localparam int NSW = 2;
  localparam int MW  = 4;
  localparam int LW  = 8;
  localparam int FD  = 4;
  localparam int FDW = 2;

  logic sysClk   = 1'b0;
  logic sysReset = 1'b0;

  always #5 sysClk = ~sysClk;

  caxi4interconnect_write_data_pop_controller_if #(
    .NUM_SLAVES(NS), .NUM_SLAVES_WIDTH(NSW),
    .MASTERID_WIDTH(MW), .LEN_WIDTH(LW)
  ) bus ();

  caxi4interconnect_write_data_pop_controller #(
    .NUM_SLAVES(NS), .NUM_SLAVES_WIDTH(NSW), .MASTERID_WIDTH(MW),
    .LEN_WIDTH(LW), .FIFO_DEPTH(FD), .FIFO_DEPTH_WIDTH(FDW)
  ) dut (
    .sysClk  (sysClk),
    .sysReset(sysReset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  logic [MW-1:0] exp_pop_q[$];
  logic [MW-1:0] mon_exp;

  // Scoreboard side: every pop must match the oldest expected ID.
  always @(negedge sysClk) begin
    if (bus.openTransDec === 1'b1) begin
      n_pops++;
      n_checks++;
      if (exp_pop_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pop with ID %0d, required no pop", bus.currDataTransID);
      end else begin
        mon_exp = exp_pop_q.pop_front();
        if (bus.currDataTransID !== mon_exp) begin
          n_fail++;
          $display("FAIL pop_id: got %0d, required %0d", bus.currDataTransID, mon_exp);
        end
      end
    end
  end

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  // Push one entry (caller knows the queue is not full); returns with the
  // entry already at the queue tail.
  task automatic push_one(input int id, input int slv, input int len);
    tick();
    bus.awPush        = 1'b1;
    bus.awPushID      = MW'(id);
    bus.awPushSlaveID = NSW'(slv);
    bus.awPushLen     = LW'(len);
    exp_pop_q.push_back(MW'(id));
    tick();
    bus.awPush = 1'b0;
  endtask

  task automatic test_reset();
    sysReset          = 1'b0;
    bus.awPush        = 1'b0;
    bus.awPushID      = '0;
    bus.awPushSlaveID = '0;
    bus.awPushLen     = '0;
    bus.mstWValid     = 1'b1;
    bus.mstWLast      = 1'b0;
    bus.slvWReady     = '1;
    tick();
    tick();
    @(negedge sysClk);
    n_checks++; if (bus.awFull !== 1'b0) begin n_fail++; $display("FAIL reset_awFull: got %b, required 0", bus.awFull); end
    n_checks++; if (bus.openTransDec !== 1'b0) begin n_fail++; $display("FAIL reset_openTransDec: got %b, required 0", bus.openTransDec); end
    n_checks++; if (bus.currDataTransID !== 4'd0) begin n_fail++; $display("FAIL reset_currDataTransID: got %0d, required 0", bus.currDataTransID); end
    n_checks++; if (bus.lastErrPulse !== 1'b0) begin n_fail++; $display("FAIL reset_lastErrPulse: got %b, required 0", bus.lastErrPulse); end
    n_checks++; if (bus.lastErrSticky !== 1'b0) begin n_fail++; $display("FAIL reset_lastErrSticky: got %b, required 0", bus.lastErrSticky); end
    n_checks++; if (bus.mstWReady !== 1'b0) begin n_fail++; $display("FAIL reset_mstWReady: got %b, required 0", bus.mstWReady); end
    n_checks++; if (bus.slvWValid !== 4'b0000) begin n_fail++; $display("FAIL reset_slvWValid: got %b, required 0000", bus.slvWValid); end
    n_checks++; if (bus.slvWLast !== 1'b0) begin n_fail++; $display("FAIL reset_slvWLast: got %b, required 0", bus.slvWLast); end
    n_checks++; if (bus.wSelSlaveID !== 2'd0) begin n_fail++; $display("FAIL reset_wSelSlaveID: got %0d, required 0", bus.wSelSlaveID); end
    tick();
    sysReset = 1'b1;
    @(negedge sysClk);
    // W data with no AW entry queued must stall.
    n_checks++; if (bus.mstWReady !== 1'b0) begin n_fail++; $display("FAIL early_w_stall: got mstWReady %b, required 0", bus.mstWReady); end
    n_checks++; if (bus.slvWValid !== 4'b0000) begin n_fail++; $display("FAIL early_w_slvWValid: got %b, required 0000", bus.slvWValid); end
    tick();
    bus.mstWValid = 1'b0;
    bus.slvWReady = '0;
  endtask

  task automatic test_single_beat();
    push_one(3, 2, 0);
    bus.mstWValid = 1'b1;
    bus.mstWLast  = 1'b1;
    bus.slvWReady = 4'b0100;
    @(negedge sysClk);
    n_checks++; if (bus.slvWValid !== 4'b0100) begin n_fail++; $display("FAIL single_slvWValid: got %b, required 0100", bus.slvWValid); end
    n_checks++; if (bus.slvWLast !== 1'b1) begin n_fail++; $display("FAIL single_slvWLast: got %b, required 1", bus.slvWLast); end
    n_checks++; if (bus.mstWReady !== 1'b1) begin n_fail++; $display("FAIL single_mstWReady: got %b, required 1", bus.mstWReady); end
    n_checks++; if (bus.wSelSlaveID !== 2'd2) begin n_fail++; $display("FAIL single_wSel: got %0d, required 2", bus.wSelSlaveID); end
    tick();
    bus.mstWValid = 1'b0;
    bus.mstWLast  = 1'b0;
    bus.slvWReady = '0;
    @(negedge sysClk);
    n_checks++; if (bus.openTransDec !== 1'b1) begin n_fail++; $display("FAIL single_pop: got openTransDec %b, required 1", bus.openTransDec); end
    n_checks++; if (bus.currDataTransID !== 4'd3) begin n_fail++; $display("FAIL single_pop_id: got %0d, required 3", bus.currDataTransID); end
    tick();
    @(negedge sysClk);
    n_checks++; if (bus.openTransDec !== 1'b0) begin n_fail++; $display("FAIL single_pop_width: got openTransDec %b, required 0", bus.openTransDec); end
    n_checks++; if (bus.currDataTransID !== 4'd3) begin n_fail++; $display("FAIL single_id_hold: got %0d, required 3", bus.currDataTransID); end
  endtask

  task automatic test_burst_backpressure();
    logic [4:0] rdy;
    int beats;
    int pops_before;
    rdy   = 5'b11101;  // slvWReady[1] per cycle, LSB first: 1,0,1,1,1
    beats = 0;
    push_one(5, 1, 3);
    pops_before   = n_pops;
    bus.mstWValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.slvWReady = NS'(rdy[i]) << 1;
      bus.mstWLast  = (beats == 3);
      @(negedge sysClk);
      n_checks++; if (bus.mstWReady !== rdy[i]) begin n_fail++; $display("FAIL burst_mstWReady[%0d]: got %b, required %b", i, bus.mstWReady, rdy[i]); end
      if (bus.mstWReady === 1'b1) begin
        n_checks++; if (bus.slvWLast !== (beats == 3)) begin n_fail++; $display("FAIL burst_slvWLast beat %0d: got %b, required %b", beats, bus.slvWLast, (beats == 3)); end
        beats++;
      end
      tick();
    end
    bus.mstWValid = 1'b0;
    bus.mstWLast  = 1'b0;
    bus.slvWReady = '0;
    n_checks++; if (beats !== 4) begin n_fail++; $display("FAIL burst_beat_count: got %0d, required 4", beats); end
    tick();
    tick();
    n_checks++; if (n_pops - pops_before !== 1) begin n_fail++; $display("FAIL burst_pop_count: got %0d, required 1", n_pops - pops_before); end
  endtask

  task automatic test_back_to_back();
    int         exp_sel  [3] = '{0, 0, 3};
    logic       exp_last [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] ev;
    tick();
    bus.awPush = 1'b1; bus.awPushID = 4'd1; bus.awPushSlaveID = 2'd0; bus.awPushLen = 8'd1;
    exp_pop_q.push_back(4'd1);
    tick();
    bus.awPushID = 4'd2; bus.awPushSlaveID = 2'd3; bus.awPushLen = 8'd0;
    exp_pop_q.push_back(4'd2);
    tick();
    bus.awPush    = 1'b0;
    bus.mstWValid = 1'b1;
    bus.slvWReady = '1;
    for (int i = 0; i < 3; i++) begin
      bus.mstWLast = exp_last[i];
      ev = 4'b0001 << exp_sel[i];
      @(negedge sysClk);
      n_checks++; if (bus.mstWReady !== 1'b1) begin n_fail++; $display("FAIL b2b_mstWReady[%0d]: got %b, required 1", i, bus.mstWReady); end
      n_checks++; if (bus.wSelSlaveID !== NSW'(exp_sel[i])) begin n_fail++; $display("FAIL b2b_wSel[%0d]: got %0d, required %0d", i, bus.wSelSlaveID, exp_sel[i]); end
      n_checks++; if (bus.slvWLast !== exp_last[i]) begin n_fail++; $display("FAIL b2b_slvWLast[%0d]: got %b, required %b", i, bus.slvWLast, exp_last[i]); end
      n_checks++; if (bus.slvWValid !== ev) begin n_fail++; $display("FAIL b2b_slvWValid[%0d]: got %b, required %b", i, bus.slvWValid, ev); end
      if (i == 2) begin
        n_checks++; if (bus.openTransDec !== 1'b1 || bus.currDataTransID !== 4'd1) begin n_fail++; $display("FAIL b2b_pop1: got dec %b id %0d, required dec 1 id 1", bus.openTransDec, bus.currDataTransID); end
      end
      tick();
    end
    bus.mstWValid = 1'b0;
    bus.mstWLast  = 1'b0;
    @(negedge sysClk);
    n_checks++; if (bus.openTransDec !== 1'b1 || bus.currDataTransID !== 4'd2) begin n_fail++; $display("FAIL b2b_pop2: got dec %b id %0d, required dec 1 id 2", bus.openTransDec, bus.currDataTransID); end
    tick();
    bus.slvWReady = '0;
  endtask

  task automatic test_full_queue();
    int ids  [4] = '{8, 9, 10, 11};
    int lens [4] = '{1, 0, 2, 0};
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.awPush = 1'b1; bus.awPushID = MW'(ids[i]); bus.awPushSlaveID = NSW'(i); bus.awPushLen = LW'(lens[i]);
      exp_pop_q.push_back(MW'(ids[i]));
      @(negedge sysClk);
      n_checks++; if (bus.awFull !== 1'b0) begin n_fail++; $display("FAIL full_early[%0d]: got awFull %b, required 0", i, bus.awFull); end
    end
    tick();
    bus.awPush = 1'b0;
    @(negedge sysClk);
    n_checks++; if (bus.awFull !== 1'b1) begin n_fail++; $display("FAIL full_flag: got awFull %b, required 1", bus.awFull); end
    // First beat of entry 0 (len 1).
    tick();
    bus.mstWValid = 1'b1; bus.slvWReady = '1; bus.mstWLast = 1'b0;
    @(negedge sysClk);
    n_checks++; if (bus.slvWLast !== 1'b0) begin n_fail++; $display("FAIL full_beat0_last: got %b, required 0", bus.slvWLast); end
    // Last beat of entry 0 with a fifth push that must be dropped.
    tick();
    bus.mstWLast = 1'b1;
    bus.awPush = 1'b1; bus.awPushID = 4'd12; bus.awPushSlaveID = 2'd1; bus.awPushLen = 8'd0;
    @(negedge sysClk);
    n_checks++; if (bus.slvWLast !== 1'b1 || bus.awFull !== 1'b1) begin n_fail++; $display("FAIL full_coincident: got slvWLast %b awFull %b, required 1 1", bus.slvWLast, bus.awFull); end
    for (int e = 1; e < 4; e++) begin
      for (int b = 0; b <= lens[e]; b++) begin
        tick();
        bus.awPush   = 1'b0;
        bus.mstWLast = (b == lens[e]);
        @(negedge sysClk);
        n_checks++; if (bus.wSelSlaveID !== NSW'(e) || bus.mstWReady !== 1'b1 || bus.slvWLast !== (b == lens[e])) begin
          n_fail++; $display("FAIL full_drain e%0d b%0d: got sel %0d rdy %b last %b, required sel %0d rdy 1 last %b", e, b, bus.wSelSlaveID, bus.mstWReady, bus.slvWLast, e, (b == lens[e]));
        end
      end
    end
    tick();
    bus.mstWLast = 1'b0;
    tick();
    tick();
    @(negedge sysClk);
    // The dropped entry would show up here as a still-valid head.
    n_checks++; if (bus.mstWReady !== 1'b0 || bus.awFull !== 1'b0 || bus.wSelSlaveID !== 2'd0) begin n_fail++; $display("FAIL full_empty_after: got rdy %b full %b sel %0d, required 0 0 0", bus.mstWReady, bus.awFull, bus.wSelSlaveID); end
    n_checks++; if (exp_pop_q.size() !== 0) begin n_fail++; $display("FAIL full_pops_missing: got %0d outstanding, required 0", exp_pop_q.size()); end
    tick();
    bus.mstWValid = 1'b0;
    bus.slvWReady = '0;
  endtask

  task automatic test_wlast_mismatch();
    @(negedge sysClk);
    n_checks++; if (bus.lastErrSticky !== 1'b0) begin n_fail++; $display("FAIL err_sticky_pre: got %b, required 0", bus.lastErrSticky); end
    push_one(6, 0, 1);
    bus.mstWValid = 1'b1; bus.slvWReady = '1; bus.mstWLast = 1'b1;  // early WLAST
    @(negedge sysClk);
    n_checks++; if (bus.slvWLast !== 1'b0 || bus.lastErrPulse !== 1'b0) begin n_fail++; $display("FAIL err_beat1: got slvWLast %b pulse %b, required 0 0", bus.slvWLast, bus.lastErrPulse); end
    tick();
    bus.mstWLast = 1'b1;
    @(negedge sysClk);
    n_checks++; if (bus.lastErrPulse !== 1'b1 || bus.lastErrSticky !== 1'b1) begin n_fail++; $display("FAIL err_flag: got pulse %b sticky %b, required 1 1", bus.lastErrPulse, bus.lastErrSticky); end
    n_checks++; if (bus.slvWLast !== 1'b1 || bus.mstWReady !== 1'b1) begin n_fail++; $display("FAIL err_beat2: got slvWLast %b rdy %b, required 1 1", bus.slvWLast, bus.mstWReady); end
    tick();
    bus.mstWValid = 1'b0; bus.mstWLast = 1'b0;
    @(negedge sysClk);
    n_checks++; if (bus.lastErrPulse !== 1'b0 || bus.lastErrSticky !== 1'b1) begin n_fail++; $display("FAIL err_after: got pulse %b sticky %b, required 0 1", bus.lastErrPulse, bus.lastErrSticky); end
    n_checks++; if (bus.openTransDec !== 1'b1 || bus.currDataTransID !== 4'd6) begin n_fail++; $display("FAIL err_pop: got dec %b id %0d, required 1 6", bus.openTransDec, bus.currDataTransID); end
    tick();
    bus.slvWReady = '0;
  endtask

  task automatic test_reset_mid_burst();
    push_one(7, 3, 7);
    bus.mstWValid = 1'b1; bus.slvWReady = '1; bus.mstWLast = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysClk);
      n_checks++; if (bus.mstWReady !== 1'b1) begin n_fail++; $display("FAIL rst_pre_beat[%0d]: got %b, required 1", i, bus.mstWReady); end
      tick();
    end
    sysReset      = 1'b0;
    bus.mstWValid = 1'b0;
    exp_pop_q.delete();  // reset discards the partial burst without a pop
    tick();
    sysReset      = 1'b1;
    bus.mstWValid = 1'b1;
    @(negedge sysClk);
    n_checks++; if (bus.mstWReady !== 1'b0 || bus.slvWValid !== 4'b0000 || bus.slvWLast !== 1'b0 || bus.wSelSlaveID !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid_comb: got rdy %b valid %b last %b sel %0d, required 0 0000 0 0", bus.mstWReady, bus.slvWValid, bus.slvWLast, bus.wSelSlaveID);
    end
    n_checks++; if (bus.awFull !== 1'b0 || bus.openTransDec !== 1'b0 || bus.currDataTransID !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid_regs: got full %b dec %b id %0d, required 0 0 0", bus.awFull, bus.openTransDec, bus.currDataTransID);
    end
    n_checks++; if (bus.lastErrPulse !== 1'b0 || bus.lastErrSticky !== 1'b0) begin n_fail++; $display("FAIL rst_mid_err: got pulse %b sticky %b, required 0 0", bus.lastErrPulse, bus.lastErrSticky); end
    tick();
    bus.mstWValid = 1'b0;
    tick();
    // Fresh burst: a stale beat count would raise slvWLast too early.
    push_one(4, 1, 3);
    bus.mstWValid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      bus.mstWLast = (b == 3);
      @(negedge sysClk);
      n_checks++; if (bus.mstWReady !== 1'b1 || bus.wSelSlaveID !== 2'd1 || bus.slvWLast !== (b == 3)) begin
        n_fail++; $display("FAIL rst_post_beat[%0d]: got rdy %b sel %0d last %b, required 1 1 %b", b, bus.mstWReady, bus.wSelSlaveID, bus.slvWLast, (b == 3));
      end
      tick();
    end
    bus.mstWValid = 1'b0; bus.mstWLast = 1'b0; bus.slvWReady = '0;
    tick();
    tick();
    n_checks++; if (exp_pop_q.size() !== 0) begin n_fail++; $display("FAIL rst_post_pop: got %0d outstanding, required 0", exp_pop_q.size()); end
    n_checks++; if (bus.lastErrSticky !== 1'b0) begin n_fail++; $display("FAIL rst_post_sticky: got %b, required 0", bus.lastErrSticky); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_beat();
    test_burst_backpressure();
    test_back_to_back();
    test_full_queue();
    test_wlast_mismatch();
    test_reset_mid_burst();
    tick();
    tick();
    n_checks++; if (exp_pop_q.size() !== 0) begin n_fail++; $display("FAIL final_outstanding: got %0d, required 0", exp_pop_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/caxi4interconnect_write_data_pop_controller.md
Name: caxi4interconnect_write_data_pop_controller

Overview:
- Completion side of the per-master open-transaction bookkeeping.
- Queues accepted write-address grants in order (ID, slaveID, AWLEN), steers the master W channel handshake to the granted slave and counts beats.
- On each accepted last beat it pops the transaction: a one-cycle openTransDec pulse with currDataTransID, consumed by the transaction-tracking block.
- Flags WLAST/AWLEN mismatches.

Parameters:
- NUM_SLAVES, 4, number of slave ports (one-hot W steering width).
- NUM_SLAVES_WIDTH, 2, bits to encode a slave number.
- MASTERID_WIDTH, 4, width of transaction ID.
- LEN_WIDTH, 8, AXI4 burst length field width (beats-1).
- FIFO_DEPTH, 4, outstanding address entries queued; power of 2.
- FIFO_DEPTH_WIDTH, 2, log2(FIFO_DEPTH).

Ports:
- sysClk  input  1  system clock, all logic on rising edge.
- sysReset  input  1  reset, synchronous, active-low.
- awPush  input  1  address granted to a slave; enqueue entry.
- awPushID  input  MASTERID_WIDTH  ID of granted transaction.
- awPushSlaveID  input  NUM_SLAVES_WIDTH  target slave.
- awPushLen  input  LEN_WIDTH  AWLEN (beats-1).
- awFull  output  1  queue full; awPush ignored while high.
- mstWValid  input  1  master WVALID.
- mstWLast  input  1  master WLAST.
- mstWReady  output  1  WREADY to master.
- slvWValid  output  NUM_SLAVES  one-hot WVALID to slaves.
- slvWReady  input  NUM_SLAVES  WREADY from slaves.
- slvWLast  output  1  generated WLAST to slaves.
- wSelSlaveID  output  NUM_SLAVES_WIDTH  slave selected for W data mux.
- currDataTransID  output  MASTERID_WIDTH  ID of popped transaction.
- openTransDec  output  1  one-cycle pop pulse.
- lastErrPulse  output  1  one-cycle WLAST mismatch pulse.
- lastErrSticky  output  1  sticky mismatch flag.

Behaviour:
- Reset (sysReset low at rising edge): FIFO empty, count=0, beatCnt=0, awFull=0, openTransDec=0, currDataTransID=0, lastErrPulse=0, lastErrSticky=0. Combinational outputs settle to mstWReady=0, slvWValid=0, slvWLast=0, wSelSlaveID=0 (empty head). Reset mid-burst discards all entries and the partial beat count; no pop is issued for discarded entries.
- FIFO:
  - Circular buffer with wrPtr/rdPtr of FIFO_DEPTH_WIDTH bits, wrapping modulo FIFO_DEPTH.
  - count is FIFO_DEPTH_WIDTH+1 bits; awFull = (count == FIFO_DEPTH), registered from count.
  - Push when awPush & !awFull. A push while full is dropped, including when a pop occurs in the same cycle.
  - No bypass: an entry pushed into an empty FIFO becomes head on the next cycle.
- Head valid = count != 0. wSelSlaveID = head slaveID when valid, else 0.
- Steering (combinational):
  - slvWValid[k] = headValid & mstWValid & (head slaveID == k).
  - mstWReady = headValid & slvWReady[head slaveID].
  - W beats presented before their AW entry stalls (mstWReady=0).
- Beats:
  - beat = mstWValid & mstWReady; beatCnt is LEN_WIDTH bits.
  - slvWLast = headValid & (beatCnt == head len). The generated value is sent to the slave, never mstWLast.
  - On a beat that is not last: beatCnt+1.
  - On a last beat: beatCnt←0, rdPtr advances, count decrements (net unchanged if a push is accepted in the same cycle).
  - The next entry's beats are accepted the following cycle with no bubble.
- Pop:
  - The cycle after a last beat, openTransDec=1 and currDataTransID = ID of the completed entry; otherwise openTransDec=0.
  - currDataTransID holds its value until the next pop.
- Error:
  - On any beat where mstWLast != slvWLast: lastErrPulse=1 next cycle and lastErrSticky is set; it clears only on reset.
  - Burst progress follows AWLEN regardless of mstWLast.
- AWLEN=0: the first beat is the last beat.

Test Plan:
- Single beat:
  - Stimulus: push ID=3, slave=2, len=0; one cycle later mstWValid=mstWLast=1, slvWReady=4'b0100.
  - Required: slvWValid=4'b0100, slvWLast=1, mstWReady=1; next cycle openTransDec=1, currDataTransID=3.
- Burst with backpressure:
  - Stimulus: push ID=5, slave=1, len=3; toggle slvWReady[1] 1,0,1,1,1.
  - Required: exactly 4 beats accepted; slvWLast only on beat 4; single pop with ID=5.
- Back-to-back:
  - Stimulus: push ID=1/slave0/len1, then ID=2/slave3/len0; mstWValid held high, all ready.
  - Required: beats in 3 consecutive cycles; wSelSlaveID 0,0,3; pops ID=1 then ID=2 on consecutive cycles.
- Full queue:
  - Stimulus: 4 pushes without W traffic, then a 5th push coincident with a last beat.
  - Required: awFull=1 after the 4th push; 5th entry dropped; after the 4 bursts, no 5th pop; count wraps correctly.
- WLAST mismatch:
  - Stimulus: len=1 with mstWLast=1 on beat 1.
  - Required: lastErrPulse=1 for one cycle; lastErrSticky=1; burst still completes on beat 2 with one pop.
- Reset mid-burst:
  - Stimulus: len=7 burst, assert sysReset low after beat 3 for one edge.
  - Required: all outputs at reset values; no openTransDec; a subsequent new push/burst operates normally.
